// File: rtl/ctrl_pkg.sv
// Shared definitions for the controller / fetch-unit handshake:
// state encodings, the NOP instruction word and default bus widths.
package ctrl_pkg;

  localparam int DEF_AW = 8;
  localparam int DEF_DW = 16;

  // Kept as plain 2-bit constants so older blocks that compare raw state values still match.
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RD_WAIT = 2'd1;
  localparam logic [1:0] RI_DONE = 2'd2;
  localparam logic [1:0] PC_DONE = 2'd3;

  localparam logic [DEF_DW-1:0] NOP = '0;

endpackage : ctrl_pkg

// File: rtl/fetch_unit.sv
// Fetch/count responder: owns PC and IR, reads instruction memory with a
// bounded wait on mem_ready, and answers the controller with fim_ri / fim_pc.
module fetch_unit
  import ctrl_pkg::*;
#(
  parameter int AW  = DEF_AW,
  parameter int DW  = DEF_DW,
  parameter int TMO = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          hab_ri,
  input  logic          hab_pc,
  input  logic          jump_en,
  input  logic [AW-1:0] jump_addr,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  output logic [AW-1:0] mem_addr,
  output logic          mem_rd,
  output logic [DW-1:0] instr,
  output logic [AW-1:0] pc,
  output logic          fim_ri,
  output logic          fim_pc,
  output logic          err
);

  localparam int            CW      = $clog2(TMO + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TMO);

  logic [1:0]    state_reg, state_next;
  logic [AW-1:0] pc_reg, pc_next;
  logic [DW-1:0] instr_reg, instr_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          err_reg, err_next;

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    instr_next = instr_reg;
    cnt_next   = cnt_reg;
    err_next   = err_reg;

    case (state_reg)
      IDLE: begin
        // A fetch request outranks a simultaneous count request.
        if (hab_ri) begin
          state_next = RD_WAIT;
          cnt_next   = '0;
        end else if (hab_pc) begin
          state_next = PC_DONE;
          pc_next    = jump_en ? jump_addr : pc_reg + AW'(1);
        end
      end

      RD_WAIT: begin
        // Data arriving on the timeout cycle still wins over the abort.
        if (mem_ready) begin
          instr_next = mem_rdata;
          state_next = RI_DONE;
        end else if (cnt_reg == CNT_MAX) begin
          instr_next = DW'(NOP);
          err_next   = 1'b1;
          state_next = RI_DONE;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end

      RI_DONE: begin
        if (!hab_ri) begin
          state_next = IDLE;
        end
      end

      PC_DONE: begin
        if (!hab_pc) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      pc_reg    <= '0;
      instr_reg <= '0;
      cnt_reg   <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      instr_reg <= instr_next;
      cnt_reg   <= cnt_next;
      err_reg   <= err_next;
    end
  end

  // Handshake outputs are pure state decodes so reset clears them at once.
  assign mem_rd   = (state_reg == RD_WAIT);
  assign fim_ri   = (state_reg == RI_DONE);
  assign fim_pc   = (state_reg == PC_DONE);
  assign mem_addr = pc_reg;
  assign pc       = pc_reg;
  assign instr    = instr_reg;
  assign err      = err_reg;

endmodule : fetch_unit

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: table-driven fetch and PC-update vectors
// plus hand-written sequences for enable collision, abort and async reset.
module tb_fetch_unit;

  localparam int AW  = 8;
  localparam int DW  = 16;
  localparam int TMO = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic          hab_ri, hab_pc, jump_en, mem_ready;
  logic [AW-1:0] jump_addr;
  logic [DW-1:0] mem_rdata;
  logic [AW-1:0] mem_addr, pc;
  logic          mem_rd, fim_ri, fim_pc, err;
  logic [DW-1:0] instr;

  int checks   = 0;
  int failures = 0;

  fetch_unit #(.AW(AW), .DW(DW), .TMO(TMO)) dut (
    .clk       (clk),
    .rst       (rst),
    .hab_ri    (hab_ri),
    .hab_pc    (hab_pc),
    .jump_en   (jump_en),
    .jump_addr (jump_addr),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_rd    (mem_rd),
    .instr     (instr),
    .pc        (pc),
    .fim_ri    (fim_ri),
    .fim_pc    (fim_pc),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]    waits;
    logic          never;
    logic [DW-1:0] rdata;
    logic [DW-1:0] exp_instr;
    logic [7:0]    exp_lat;
    logic          exp_err;
  } fetch_vec_t;

  typedef struct packed {
    logic          jump;
    logic [AW-1:0] target;
    logic [AW-1:0] exp_pc;
  } pc_vec_t;

  fetch_vec_t fvec[6];
  pc_vec_t    pvec[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Run one fetch handshake; memory holds off mem_ready for 'waits' RD_WAIT cycles.
  task automatic fetch(input int waits, input bit never, input logic [DW-1:0] data,
                       output int lat, output int rd_cycles, output logic [AW-1:0] addr);
    lat       = -1;
    rd_cycles = 0;
    addr      = '1;
    mem_rdata = data;
    mem_ready = (waits == 0) && !never;
    hab_ri    = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      tick();
      if (fim_ri) begin
        lat = c;
        break;
      end
      if (mem_rd) begin
        if (rd_cycles == 0) addr = mem_addr;
        rd_cycles++;
      end
      mem_ready = !never && (c > waits);
    end
    hab_ri    = 1'b0;
    mem_ready = 1'b0;
    tick();
    chk("fim_ri_release", {31'd0, fim_ri}, 32'd0);
  endtask

  task automatic pc_update(input logic jump, input logic [AW-1:0] target,
                           input logic [AW-1:0] exp_pc, input string tag);
    hab_pc    = 1'b1;
    jump_en   = jump;
    jump_addr = target;
    tick();
    chk({tag, "_fim_pc_rise"}, {31'd0, fim_pc}, 32'd1);
    chk({tag, "_pc"}, {24'd0, pc}, {24'd0, exp_pc});
    hab_pc  = 1'b0;
    jump_en = 1'b0;
    tick();
    chk({tag, "_fim_pc_fall"}, {31'd0, fim_pc}, 32'd0);
    $display("pc_update %s: jump=%0b target=%02h pc=%02h", tag, jump, target, pc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int            lat, rdc;
    logic [AW-1:0] addr, pc_before;

    //          waits never rdata     instr     lat  err
    fvec[0] = '{8'd0,  1'b0, 16'hA55A, 16'hA55A, 8'd2,  1'b0};
    fvec[1] = '{8'd3,  1'b0, 16'h1234, 16'h1234, 8'd5,  1'b0};
    fvec[2] = '{8'd1,  1'b0, 16'hBEEF, 16'hBEEF, 8'd3,  1'b0};
    fvec[3] = '{8'd15, 1'b0, 16'h5EED, 16'h5EED, 8'd17, 1'b0};
    fvec[4] = '{8'd0,  1'b1, 16'hDEAD, 16'h0000, 8'd17, 1'b1};
    fvec[5] = '{8'd0,  1'b0, 16'hC0DE, 16'hC0DE, 8'd2,  1'b1};

    pvec[0] = '{1'b1, 8'hFE, 8'hFE};
    pvec[1] = '{1'b0, 8'h77, 8'hFF};
    pvec[2] = '{1'b0, 8'h00, 8'h00};
    pvec[3] = '{1'b1, 8'h3C, 8'h3C};
    pvec[4] = '{1'b0, 8'h00, 8'h3D};

    rst = 1'b1; hab_ri = 1'b0; hab_pc = 1'b0; jump_en = 1'b0;
    jump_addr = '0; mem_rdata = '0; mem_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("rst_pc", {24'd0, pc}, 32'd0);
    chk("rst_instr", {16'd0, instr}, 32'd0);
    chk("rst_flags", {27'd0, fim_ri, fim_pc, err, mem_rd, 1'b0}, 32'd0);

    for (int i = 0; i < 6; i++) begin
      fetch(int'(fvec[i].waits), fvec[i].never, fvec[i].rdata, lat, rdc, addr);
      $display("fetch %0d: waits=%0d lat=%0d rd_cycles=%0d instr=%04h err=%0b",
               i, fvec[i].waits, lat, rdc, instr, err);
      chk("fetch_latency", lat, {24'd0, fvec[i].exp_lat});
      chk("fetch_rd_cycles", rdc, {24'd0, fvec[i].exp_lat} - 32'd1);
      chk("fetch_instr", {16'd0, instr}, {16'd0, fvec[i].exp_instr});
      chk("fetch_err", {31'd0, err}, {31'd0, fvec[i].exp_err});
      chk("fetch_addr", {24'd0, addr}, 32'd0);
    end

    for (int i = 0; i < 5; i++) begin
      pc_update(pvec[i].jump, pvec[i].target, pvec[i].exp_pc, $sformatf("pc%0d", i));
    end

    // Both enables in IDLE: fetch wins, count waits until IDLE again.
    pc_before = pc;
    hab_pc    = 1'b1;
    fetch(0, 1'b0, 16'h4242, lat, rdc, addr);
    $display("collision fetch: lat=%0d instr=%04h pc=%02h fim_pc=%0b", lat, instr, pc, fim_pc);
    chk("coll_lat", lat, 32'd2);
    chk("coll_addr", {24'd0, addr}, {24'd0, pc_before});
    chk("coll_pc_held", {24'd0, pc}, {24'd0, pc_before});
    chk("coll_fim_pc_low", {31'd0, fim_pc}, 32'd0);
    tick();
    chk("coll_fim_pc_late", {31'd0, fim_pc}, 32'd1);
    chk("coll_pc_inc", {24'd0, pc}, {24'd0, pc_before + 8'd1});
    hab_pc = 1'b0;
    tick();

    // Controller abort: hab_ri drops while the read is still outstanding.
    hab_ri = 1'b1; mem_ready = 1'b0; mem_rdata = 16'h7777;
    tick();
    chk("abort_rd", {31'd0, mem_rd}, 32'd1);
    hab_ri = 1'b0;
    tick();
    chk("abort_still_rd", {31'd0, mem_rd}, 32'd1);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    chk("abort_fim_ri", {31'd0, fim_ri}, 32'd1);
    chk("abort_instr", {16'd0, instr}, 32'h7777);
    tick();
    chk("abort_idle", {30'd0, fim_ri, mem_rd}, 32'd0);
    $display("abort fetch: instr=%04h", instr);

    // Async reset between edges while in RD_WAIT.
    hab_ri = 1'b1; mem_ready = 1'b0;
    tick(); tick();
    chk("arst_pre_rd", {31'd0, mem_rd}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_mem_rd", {31'd0, mem_rd}, 32'd0);
    chk("arst_pc", {24'd0, pc}, 32'd0);
    chk("arst_instr", {16'd0, instr}, 32'd0);
    chk("arst_err", {31'd0, err}, 32'd0);
    hab_ri = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    fetch(0, 1'b0, 16'h0F0F, lat, rdc, addr);
    $display("post-reset fetch: addr=%02h instr=%04h lat=%0d", addr, instr, lat);
    chk("arst_refetch_addr", {24'd0, addr}, 32'd0);
    chk("arst_refetch_instr", {16'd0, instr}, 32'h0F0F);
    chk("arst_refetch_err", {31'd0, err}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_fetch_unit

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Responder side of the controller's fetch/count handshake: it receives `hab_ri` and `hab_pc`, and returns `fim_ri` and `fim_pc`.
- Owns the program counter (PC) and the instruction register (IR).
- Reads instruction memory through a ready-based read port.
- Sits between the top-level Moore controller and instruction memory, and feeds IR to the decode logic.

Parameters:
- AW, 8, PC / memory address width.
- DW, 16, instruction word width.
- TMO, 15, maximum cycles to wait for `mem_ready` before aborting a fetch; must be >= 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- hab_ri  in  1  fetch enable from controller; level, held for the whole fetch state.
- hab_pc  in  1  PC-update enable from controller; level, held for the whole count state.
- jump_en  in  1  sampled when a PC update starts; 1 selects `jump_addr`.
- jump_addr  in  AW  branch target.
- mem_rdata  in  DW  instruction memory read data.
- mem_ready  in  1  memory read data valid this cycle.
- mem_addr  out  AW  read address; always equals `pc`.
- mem_rd  out  1  read request.
- instr  out  DW  instruction register.
- pc  out  AW  program counter.
- fim_ri  out  1  fetch done.
- fim_pc  out  1  PC update done.
- err  out  1  sticky fetch-timeout flag.

Behaviour:
- Reset (async, immediate, also mid-operation): state IDLE; `pc`, `instr`, wait counter, `err`, `mem_rd`, `fim_ri` and `fim_pc` all 0. Any pending fetch is abandoned.
- All outputs are registered or decoded from state only (Moore).
- `mem_addr` is combinationally equal to `pc`.
- States: IDLE, RD_WAIT, RI_DONE, PC_DONE.
- IDLE:
  - `hab_ri`=1 -> RD_WAIT; clear wait counter.
  - else `hab_pc`=1 -> PC_DONE; on that same edge, `pc` <= `jump_en` ? `jump_addr` : `pc`+1. The increment wraps modulo 2^AW (all-ones -> 0).
  - Both asserted (illegal): `hab_ri` wins; `hab_pc` is ignored until the unit returns to IDLE.
- RD_WAIT:
  - `mem_rd`=1 every cycle in this state.
  - `mem_ready`=1 -> `instr` <= `mem_rdata`; go to RI_DONE.
  - If the counter reaches TMO with no `mem_ready`: `instr` <= 0 (NOP), `err` <= 1; go to RI_DONE.
  - `mem_ready` on the same cycle the counter hits TMO: the data is accepted and `err` is not set.
  - Counter width is clog2(TMO+1); it saturates and never wraps.
- RI_DONE: `fim_ri`=1. Stay while `hab_ri`=1; return to IDLE the cycle `hab_ri` is seen 0 (4-phase handshake).
- PC_DONE: `fim_pc`=1. Stay while `hab_pc`=1; IDLE when `hab_pc`=0.
- Latency:
  - Fetch: `fim_ri` rises 2 cycles after `hab_ri` rises when `mem_ready` is already high in the first RD_WAIT cycle; add 1 cycle per wait cycle.
  - PC update: `fim_pc` rises 1 cycle after `hab_pc` rises.
- `hab_ri` dropping during RD_WAIT (controller abort): finish the read or time out, enter RI_DONE for exactly one cycle, then go to IDLE. `instr` is still updated.
- `err` clears only on reset.
- `pc` changes only on a PC-update start; `instr` changes only on fetch completion.

Decomposition:
- Shared package `ctrl_pkg`:
  - state encoding constants: IDLE=0, RD_WAIT=1, RI_DONE=2, PC_DONE=3;
  - NOP encoding (all zeros);
  - default AW and DW.
- No sub-module is needed. The PC next-value mux and incrementer stay inline.

Test Plan:
- Reset then idle: `rst` pulse -> `pc`=0, `instr`=0, `fim_ri`=0, `fim_pc`=0, `err`=0, `mem_rd`=0.
- Zero-wait fetch:
  - Stimulus: `hab_ri`=1 with `mem_ready`=1 and `mem_rdata`=16'hA55A; drop `hab_ri` after `fim_ri` is seen.
  - Response: `mem_rd` high for 1 cycle; `instr`=A55A; `fim_ri` high 2 cycles after `hab_ri` rises; `fim_ri` low 1 cycle after `hab_ri` falls.
- Wait states and timeout:
  - 3 wait cycles then ready: `fim_ri` rises 5 cycles after `hab_ri`.
  - `mem_ready` never asserted, TMO=15: `instr`=0, `err`=1, `fim_ri` high; `err` persists through later good fetches.
- PC count, wrap and jump:
  - `pc`=8'hFE, two `hab_pc` handshakes with `jump_en`=0 -> `pc`=FF, then 00.
  - `jump_en`=1, `jump_addr`=8'h3C -> `pc`=3C; `fim_pc` rises 1 cycle after `hab_pc`.
- Simultaneous enables: `hab_ri`=`hab_pc`=1 in IDLE -> fetch proceeds, `pc` unchanged, `fim_pc` stays 0 until a later `hab_pc` seen in IDLE.
- Async reset mid-fetch: `rst` asserted in RD_WAIT between clock edges -> outputs zero immediately, without waiting for a clock edge; after release, the next `hab_ri` fetches from address 0.
